// File: rtl/pc_source_reg.sv
// pc_source_reg: next-PC selector with an owned PC register.
//
// Picks the next PC from NUM_SRC candidate buses and holds it. A PC write
// requested during a stall is buffered and committed on the first
// non-stalled edge. Misaligned targets trap to EXC_VECTOR. Out-of-range
// selectors raise a sticky error.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   selector    source index
//   data_in     candidate buses; source k is data_in[k*WIDTH +: WIDTH]
//   pc_write    load request this cycle
//   stall       blocks the PC update; a request made during a stall is buffered
//   err_clear   clears illegal_sel
//   pc_out      current PC
//   pc_prev     PC before the last successful update, traps included
//   pending     a buffered request is waiting
//   illegal_sel sticky: a request used selector >= NUM_SRC
//   misalign    one-cycle pulse when a trap is taken
//   bad_addr    offending target of the last trap
module pc_source_reg #(
  parameter int unsigned       WIDTH       = 32,
  parameter int unsigned       NUM_SRC     = 5,
  parameter int unsigned       SEL_W       = 3,
  parameter logic [WIDTH-1:0]  RESET_PC    = 32'h0000_0000,
  parameter logic [WIDTH-1:0]  EXC_VECTOR  = 32'h0000_00FF,
  parameter bit                ALIGN_CHECK = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         selector,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic                     pc_write,
  input  logic                     stall,
  input  logic                     err_clear,
  output logic [WIDTH-1:0]         pc_out,
  output logic [WIDTH-1:0]         pc_prev,
  output logic                     pending,
  output logic                     illegal_sel,
  output logic                     misalign,
  output logic [WIDTH-1:0]         bad_addr
);

  // One extra bit so NUM_SRC == 2**SEL_W is representable.
  localparam logic [SEL_W:0] NumSrcW = (SEL_W+1)'(NUM_SRC);

  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    return {1'b0, s} < NumSrcW;
  endfunction

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             pending_q, pending_d;
  logic             illegal_q, illegal_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] bad_q, bad_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;

  logic [WIDTH-1:0] live_val;
  logic             req;
  logic [SEL_W-1:0] eff_sel;
  logic [WIDTH-1:0] eff_val;

  // Live slice for the current selector; zero when out of range.
  always_comb begin
    live_val = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (selector == SEL_W'(k)) live_val = data_in[k*WIDTH +: WIDTH];
    end
  end

  // Effective request in a run cycle: live write beats the buffered one.
  always_comb begin
    req     = 1'b0;
    eff_sel = selector;
    eff_val = live_val;
    if (pc_write) begin
      req = 1'b1;
    end else if (pending_q) begin
      req     = 1'b1;
      eff_sel = pend_sel_q;
      eff_val = pend_val_q;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    prev_d     = prev_q;
    pending_d  = pending_q;
    illegal_d  = illegal_q;
    misalign_d = 1'b0;
    bad_d      = bad_q;
    pend_sel_d = pend_sel_q;
    pend_val_d = pend_val_q;

    // Clear first so a same-cycle illegal request wins.
    if (err_clear) illegal_d = 1'b0;

    if (stall) begin
      if (pc_write) begin
        if (sel_ok(selector)) begin
          pend_val_d = live_val;
          pend_sel_d = selector;
          pending_d  = 1'b1;
        end else begin
          illegal_d = 1'b1;
        end
      end
    end else begin
      pending_d = 1'b0;
      if (req) begin
        if (!sel_ok(eff_sel)) begin
          illegal_d = 1'b1;
        end else if (ALIGN_CHECK && (eff_val[1:0] != 2'b00)) begin
          pc_d       = EXC_VECTOR;
          prev_d     = pc_q;
          bad_d      = eff_val;
          misalign_d = 1'b1;
        end else begin
          pc_d   = eff_val;
          prev_d = pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      prev_q     <= RESET_PC;
      pending_q  <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      bad_q      <= '0;
      pend_sel_q <= '0;
      pend_val_q <= '0;
    end else begin
      pc_q       <= pc_d;
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      illegal_q  <= illegal_d;
      misalign_q <= misalign_d;
      bad_q      <= bad_d;
      pend_sel_q <= pend_sel_d;
      pend_val_q <= pend_val_d;
    end
  end

  assign pc_out      = pc_q;
  assign pc_prev     = prev_q;
  assign pending     = pending_q;
  assign illegal_sel = illegal_q;
  assign misalign    = misalign_q;
  assign bad_addr    = bad_q;

endmodule

// File: tb/tb_pc_source_reg.sv
module tb_pc_source_reg;

  localparam int W = 32;
  localparam int N = 5;
  localparam int S = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [S-1:0]     selector;
  logic [N-1:0][W-1:0] src;
  logic             pc_write;
  logic             stall;
  logic             err_clear;
  logic [W-1:0]     pc_out;
  logic [W-1:0]     pc_prev;
  logic             pending;
  logic             illegal_sel;
  logic             misalign;
  logic [W-1:0]     bad_addr;

  always #5 clk = ~clk;

  pc_source_reg #(
    .WIDTH      (W),
    .NUM_SRC    (N),
    .SEL_W      (S),
    .RESET_PC   (32'h0000_0000),
    .EXC_VECTOR (32'h0000_00FF),
    .ALIGN_CHECK(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .selector   (selector),
    .data_in    (src),
    .pc_write   (pc_write),
    .stall      (stall),
    .err_clear  (err_clear),
    .pc_out     (pc_out),
    .pc_prev    (pc_prev),
    .pending    (pending),
    .illegal_sel(illegal_sel),
    .misalign   (misalign),
    .bad_addr   (bad_addr)
  );

  typedef struct {
    logic             rst_n;
    logic             stl;
    logic             pcw;
    logic             clr;
    logic [S-1:0]     sel;
    logic [N-1:0][W-1:0] d;
    logic [W-1:0]     e_pc;
    logic [W-1:0]     e_prev;
    logic             e_pend;
    logic             e_ill;
    logic             e_mis;
    logic [W-1:0]     e_bad;
  } vec_t;

  int applied = 0;
  int miscompares = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic st, input logic w, input logic c,
                              input logic [S-1:0] sl, input int k, input logic [W-1:0] v,
                              input logic [W-1:0] pc, input logic [W-1:0] pv,
                              input logic pd, input logic il, input logic ms,
                              input logic [W-1:0] bd);
    vec_t t;
    t.rst_n = r; t.stl = st; t.pcw = w; t.clr = c; t.sel = sl;
    t.d = '0;
    if (k >= 0 && k < N) t.d[k] = v;
    t.e_pc = pc; t.e_prev = pv; t.e_pend = pd; t.e_ill = il; t.e_mis = ms; t.e_bad = bd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t t);
    applied++;
    chk({tag, " pc_out"}, pc_out, t.e_pc);
    chk({tag, " pc_prev"}, pc_prev, t.e_prev);
    chk({tag, " pending"}, W'(pending), W'(t.e_pend));
    chk({tag, " illegal_sel"}, W'(illegal_sel), W'(t.e_ill));
    chk({tag, " misalign"}, W'(misalign), W'(t.e_mis));
    chk({tag, " bad_addr"}, bad_addr, t.e_bad);
  endtask

  task automatic apply(input vec_t t);
    @(negedge clk);
    reset = t.rst_n; stall = t.stl; pc_write = t.pcw; err_clear = t.clr;
    selector = t.sel; src = t.d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; pc_write = 1'b0; err_clear = 1'b0;
    selector = '0; src = '0;

    //            rst st  pcw clr sel   k  val           pc         prev       pd ill mis bad
    vecs.push_back(mk(0, 0, 0, 0, 3'd0, -1, 32'h0,   32'h00,  32'h00,  0, 0, 0, 32'h00));
    vecs.push_back(mk(0, 0, 0, 0, 3'd0, -1, 32'h0,   32'h00,  32'h00,  0, 0, 0, 32'h00));
    vecs.push_back(mk(1, 0, 0, 0, 3'd0, -1, 32'h0,   32'h00,  32'h00,  0, 0, 0, 32'h00));
    // Plain load
    vecs.push_back(mk(1, 0, 1, 0, 3'd2, 2, 32'h40,   32'h40,  32'h00,  0, 0, 0, 32'h00));
    // Buffered request, source changes while stalled, commit of snapshot
    vecs.push_back(mk(1, 1, 1, 0, 3'd1, 1, 32'h80,   32'h40,  32'h00,  1, 0, 0, 32'h00));
    vecs.push_back(mk(1, 1, 0, 0, 3'd1, 1, 32'h99,   32'h40,  32'h00,  1, 0, 0, 32'h00));
    vecs.push_back(mk(1, 0, 0, 0, 3'd1, 1, 32'h99,   32'h80,  32'h40,  0, 0, 0, 32'h00));
    // Live write at release supersedes buffer
    vecs.push_back(mk(1, 1, 1, 0, 3'd1, 1, 32'h80,   32'h80,  32'h40,  1, 0, 0, 32'h00));
    vecs.push_back(mk(1, 0, 1, 0, 3'd3, 3, 32'h100,  32'h100, 32'h80,  0, 0, 0, 32'h00));
    vecs.push_back(mk(1, 0, 0, 0, 3'd1, 1, 32'h80,   32'h100, 32'h80,  0, 0, 0, 32'h00));
    // Misaligned trap, one-cycle pulse
    vecs.push_back(mk(1, 0, 1, 0, 3'd0, 0, 32'h42,   32'hFF,  32'h100, 0, 0, 1, 32'h42));
    vecs.push_back(mk(1, 0, 0, 0, 3'd0, 0, 32'h42,   32'hFF,  32'h100, 0, 0, 0, 32'h42));
    // Illegal selector, sticky, clear, set wins over clear
    vecs.push_back(mk(1, 0, 1, 0, 3'd6, -1, 32'h0,   32'hFF,  32'h100, 0, 1, 0, 32'h42));
    vecs.push_back(mk(1, 0, 0, 0, 3'd0, -1, 32'h0,   32'hFF,  32'h100, 0, 1, 0, 32'h42));
    vecs.push_back(mk(1, 0, 0, 1, 3'd0, -1, 32'h0,   32'hFF,  32'h100, 0, 0, 0, 32'h42));
    vecs.push_back(mk(1, 0, 1, 1, 3'd7, -1, 32'h0,   32'hFF,  32'h100, 0, 1, 0, 32'h42));
    vecs.push_back(mk(1, 0, 0, 1, 3'd0, -1, 32'h0,   32'hFF,  32'h100, 0, 0, 0, 32'h42));
    // Illegal during stall leaves buffer empty; last buffered request wins
    vecs.push_back(mk(1, 1, 1, 0, 3'd5, -1, 32'h0,   32'hFF,  32'h100, 0, 1, 0, 32'h42));
    vecs.push_back(mk(1, 1, 1, 0, 3'd4, 4, 32'h200,  32'hFF,  32'h100, 1, 1, 0, 32'h42));
    vecs.push_back(mk(1, 1, 1, 0, 3'd2, 2, 32'h300,  32'hFF,  32'h100, 1, 1, 0, 32'h42));
    vecs.push_back(mk(1, 0, 0, 0, 3'd0, -1, 32'h0,   32'h300, 32'hFF,  0, 1, 0, 32'h42));
    // Reset while pending discards the buffer
    vecs.push_back(mk(1, 1, 1, 0, 3'd4, 4, 32'h200,  32'h300, 32'hFF,  1, 1, 0, 32'h42));
    vecs.push_back(mk(0, 1, 0, 0, 3'd0, -1, 32'h0,   32'h00,  32'h00,  0, 0, 0, 32'h00));
    vecs.push_back(mk(1, 0, 0, 0, 3'd0, -1, 32'h0,   32'h00,  32'h00,  0, 0, 0, 32'h00));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Buffered misaligned target traps when it commits at release.
    apply(mk(1, 1, 1, 0, 3'd3, 3, 32'h13, 32'h00, 32'h00, 1, 0, 0, 32'h00));
    check_all("seq_buf_trap_stall", mk(1, 1, 1, 0, 3'd3, 3, 32'h13,
                                       32'h00, 32'h00, 1, 0, 0, 32'h00));
    apply(mk(1, 1, 0, 0, 3'd3, 3, 32'h44, 32'h00, 32'h00, 1, 0, 0, 32'h00));
    check_all("seq_buf_trap_hold", mk(1, 1, 0, 0, 3'd3, 3, 32'h44,
                                      32'h00, 32'h00, 1, 0, 0, 32'h00));
    apply(mk(1, 0, 0, 0, 3'd3, 3, 32'h44, 32'hFF, 32'h00, 0, 0, 1, 32'h13));
    check_all("seq_buf_trap_fire", mk(1, 0, 0, 0, 3'd3, 3, 32'h44,
                                      32'hFF, 32'h00, 0, 0, 1, 32'h13));
    apply(mk(1, 0, 0, 0, 3'd0, -1, 32'h0, 32'hFF, 32'h00, 0, 0, 0, 32'h13));
    check_all("seq_buf_trap_after", mk(1, 0, 0, 0, 3'd0, -1, 32'h0,
                                       32'hFF, 32'h00, 0, 0, 0, 32'h13));
    // Aligned load after trap: pc_prev picks up the exception vector.
    apply(mk(1, 0, 1, 0, 3'd4, 4, 32'h1000, 32'h1000, 32'hFF, 0, 0, 0, 32'h13));
    check_all("seq_after_trap_load", mk(1, 0, 1, 0, 3'd4, 4, 32'h1000,
                                        32'h1000, 32'hFF, 0, 0, 0, 32'h13));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
